leaf_stream_packetizer: RTL and testbench

- Transmit-side packetizer for one user output stream on a leaf.
- Accepts 32-bit words from a user kernel over the ap_vld/ap_ack handshake and buffers them in a small FIFO.
- Wraps each word into a 49-bit BFT packet addressed to a configured destination leaf/port, tagged with a rolling 7-bit sequence address.
- Transmission is gated by a freespace credit counter replenished by the destination's freespace updates; the block sits between the user kernel output and the leaf's BFT output bus.

---
 rtl/leaf_stream_packetizer.sv | 106 ++++++++++
 tb/tb_leaf_stream_packetizer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_packetizer.sv
// Transmit-side BFT packetizer: buffers user words in a small FIFO and emits them
// as addressed, sequence-tagged packets, gated by a freespace credit counter.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FIFO_DEPTH            = 4,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int CREDIT_BITS           = 8,
    localparam int PTR_W                = $clog2(FIFO_DEPTH),
    localparam int CNT_W                = PTR_W + 1
) (
    input  logic                     clk_user,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic                     freespace_update,
    input  logic                     bft_stall,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    output logic [CREDIT_BITS-1:0]   credits,
    output logic [CNT_W-1:0]         fifo_count
);

    localparam logic [CREDIT_BITS+1:0] UPD_EXT      = (CREDIT_BITS+2)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CREDIT_BITS+1:0] CRED_MAX_EXT = {2'b00, {CREDIT_BITS{1'b1}}};
    localparam logic [CREDIT_BITS-1:0] CRED_RST     = CREDIT_BITS'(FREESPACE_UPDATE_SIZE);
    localparam logic [CNT_W-1:0]       CNT_FULL     = CNT_W'(FIFO_DEPTH);

    logic [PAYLOAD_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
    logic [CREDIT_BITS-1:0]   credits_q, credits_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic [CREDIT_BITS+1:0]   cred_sum;

    logic fifo_full, fifo_empty, push, consumed, load;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = vld_user2interface & ~fifo_full;
    assign consumed   = dout_q[PACKET_BITS-1] & ~bft_stall;
    // Credit is spent at load time, so a stalled packet already owns its credit.
    assign load       = (~dout_q[PACKET_BITS-1] | consumed) & ~fifo_empty & (credits_q != '0);

    assign ack_interface2user      = push;
    assign dout_leaf_interface2bft = dout_q;
    assign credits                 = credits_q;
    assign fifo_count              = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !load)      count_d = count_q + CNT_W'(1);
        else if (!push && load) count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        seq_d  = seq_q;
        dout_d = dout_q;
        if (load) begin
            dout_d = {1'b1, dest_leaf, dest_port, seq_q, mem_q[rd_ptr_q]};
            seq_d  = seq_q + NUM_ADDR_BITS'(1);
        end else if (consumed) begin
            dout_d[PACKET_BITS-1] = 1'b0;
        end
    end

    // Load never happens at zero credits, so the subtraction cannot underflow.
    always_comb begin
        cred_sum  = {2'b00, credits_q} + (freespace_update ? UPD_EXT : '0)
                  - {{(CREDIT_BITS+1){1'b0}}, load};
        credits_d = (cred_sum > CRED_MAX_EXT) ? CRED_MAX_EXT[CREDIT_BITS-1:0]
                                              : cred_sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk_user) begin
        if (push) mem_q[wr_ptr_q] <= din_leaf_user2interface;
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            credits_q <= CRED_RST;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            credits_q <= credits_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized and directed bench for leaf_stream_packetizer against a queue-based
// transaction model of the packetizer rules.
module tb_leaf_stream_packetizer;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] din = '0;
    logic        vld = 0, stall = 0, upd = 0;
    logic [4:0]  dl = '0;
    logic [3:0]  dp = '0;
    logic        ack;
    logic [48:0] dout;
    logic [7:0]  cred;
    logic [2:0]  cnt;

    int total = 0, bad = 0;

    logic [31:0] m_q[$];
    bit          m_ov;
    logic [48:0] m_dout;
    int          m_seq, m_cred;
    bit          m_push;

    leaf_stream_packetizer dut (
        .clk_user(clk), .reset(rst_n),
        .din_leaf_user2interface(din), .vld_user2interface(vld),
        .ack_interface2user(ack), .dest_leaf(dl), .dest_port(dp),
        .freespace_update(upd), .bft_stall(stall),
        .dout_leaf_interface2bft(dout), .credits(cred), .fifo_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov = 0; m_dout = '0; m_seq = 0; m_cred = 64;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic st, input logic up);
        bit cons, ld;
        vld = v; din = d; stall = st; upd = up;
        @(negedge clk);
        chk("ack", 64'(ack), 64'(v && m_q.size() < 4));
        chk("valid", 64'(dout[48]), 64'(m_ov));
        if (m_ov) chk("pkt", 64'(dout), 64'(m_dout));
        chk("credits", 64'(cred), 64'(m_cred));
        chk("count", 64'(cnt), 64'(m_q.size()));
        @(posedge clk);
        m_push = v && m_q.size() < 4;
        cons   = m_ov && !st;
        ld     = (!m_ov || cons) && m_q.size() > 0 && m_cred > 0;
        if (ld) begin
            m_dout = {1'b1, dl, dp, 7'(m_seq), m_q.pop_front()};
            m_seq  = (m_seq + 1) % 128;
            m_ov   = 1;
        end else if (cons) begin
            m_ov = 0;
        end
        m_cred = m_cred - (ld ? 1 : 0) + (up ? 64 : 0);
        if (m_cred > 255) m_cred = 255;
        if (m_push) m_q.push_back(d);
        #1;
    endtask

    task automatic push_n(input int n);
        int pushed = 0;
        int guard = 0;
        while (pushed < n && guard < 1000) begin
            cyc(1, $urandom, 0, 0);
            if (m_push) pushed++;
            guard++;
        end
        chk("push_timeout", 64'(pushed), 64'(n));
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_q.size() > 0 || m_ov) && guard < 100) begin
            cyc(0, '0, 0, 0);
            guard++;
        end
        chk("drain_timeout", 64'(guard < 100), 64'(1));
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_count", 64'(cnt), 64'(0));
        chk("rst_credits", 64'(cred), 64'(64));
        model_reset();
        vld = 0; upd = 0; stall = 0;
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'(0));
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        model_reset();
        #12 async_reset();

        // Single word: one-cycle latency into the packet register.
        dl = 5'd3; dp = 4'd2;
        cyc(1, 32'hDEADBEEF, 0, 0);
        cyc(0, '0, 0, 0);
        chk("first_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        chk("first_cred", 64'(cred), 64'(63));
        cyc(0, '0, 0, 0);

        // Burst against a stalled bus, then release.
        for (int i = 0; i < 6; i++) cyc(1, $urandom, 1, 0);
        chk("burst_full", 64'(cnt), 64'(4));
        for (int i = 0; i < 8; i++) cyc(i < 3, $urandom, 0, 0);
        drain();

        // Exhaust credits, then show a pending word waits for a freespace update.
        push_n(m_cred);
        drain();
        chk("cred_zero", 64'(cred), 64'(0));
        cyc(1, 32'h12345678, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0);
        chk("no_emit", 64'(dout[48]), 64'(0));
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 0);
        chk("emit_after_upd", 64'(dout[31:0]), 64'(32'h12345678));
        chk("cred_63", 64'(cred), 64'(63));
        drain();

        // Update coincident with the last credit being spent, then saturation.
        push_n(m_cred - 1);
        drain();
        chk("cred_one", 64'(cred), 64'(1));
        cyc(1, $urandom, 0, 0);
        cyc(0, '0, 0, 1);
        chk("cred_upd_load", 64'(cred), 64'(64));
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 0);
        chk("cred_sat", 64'(cred), 64'(255));

        // Sequence wrap across 128.
        for (int i = 0; i < 200; i++) cyc(1, $urandom, 0, (i % 64) == 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 0) begin dl = 5'($urandom); dp = 4'($urandom); end
            cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1);
        drain();

        // Reset with three words buffered and a packet stalled on the bus.
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 1, 0);
        chk("pre_rst_count", 64'(cnt), 64'(3));
        chk("pre_rst_valid", 64'(dout[48]), 64'(1));
        async_reset();
        cyc(1, 32'hCAFEF00D, 0, 0);
        cyc(0, '0, 0, 0);
        chk("post_rst_seq", 64'(dout[38:32]), 64'(0));
        chk("post_rst_pkt", 64'(dout[31:0]), 64'(32'hCAFEF00D));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
